// File: rtl/ets_card_port.sv
// ets_card_port: travel-card balance bank with load, debit-only commit, saturating top-up and idle timeout
module ets_card_port #(
   parameter int          ID_W         = 3,
   parameter logic [15:0] INIT_BALANCE = 16'd1000,
   parameter logic [7:0]  TIMEOUT      = 8'd255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            card_insert,
   input  logic [ID_W-1:0] card_id,
   input  logic            ticket_out,
   input  logic [15:0]     balance,
   input  logic            exit,
   input  logic            topup,
   input  logic [15:0]     topup_amount,
   output logic [15:0]     TC_balance,
   output logic            tc_valid,
   output logic            card_busy,
   output logic            write_ok,
   output logic            write_err,
   output logic            card_eject
);
   localparam int N = 2**ID_W;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_EJECT} state_t;
   state_t          r_state, w_next;
   logic [15:0]     r_mem [N];
   logic [ID_W-1:0] r_id;
   logic [15:0]     r_bal;
   logic            r_valid, r_prev, r_ok, r_err, r_eject;
   logic [7:0]      r_timer;
   logic            w_edge, w_exit, w_commit, w_topup, w_quiet, w_debit_ok;
   logic [16:0]     w_sum;
   logic [15:0]     w_top_bal;
   logic [7:0]      w_tnext;
   assign w_edge     = ticket_out & ~r_prev;
   assign w_debit_ok = balance <= r_bal;
   assign w_sum      = {1'b0, r_bal} + {1'b0, topup_amount};
   assign w_top_bal  = w_sum[16] ? 16'hFFFF : w_sum[15:0];
   assign w_tnext    = r_timer + 8'd1;
   // READY arbitrates exit > commit > topup > timeout; other states just sequence
   always_comb begin
      w_next   = r_state;
      w_exit   = 1'b0;
      w_commit = 1'b0;
      w_topup  = 1'b0;
      w_quiet  = 1'b0;
      case (r_state)
         S_IDLE:  w_next = card_insert ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_READY;
         S_READY: begin
            w_exit   = exit;
            w_commit = !exit && w_edge;
            w_topup  = !exit && !w_edge && topup;
            w_quiet  = !exit && !w_edge && !topup;
            w_next   = (w_exit || w_commit || (w_quiet && w_tnext == TIMEOUT)) ? S_EJECT : S_READY;
         end
         S_EJECT: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end
   // card bank: only an accepted debit or a top-up ever writes the inserted card
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) r_mem[i] <= INIT_BALANCE;
      end else if (w_commit && w_debit_ok) begin
         r_mem[r_id] <= balance;
      end else if (w_topup) begin
         r_mem[r_id] <= w_top_bal;
      end
   end
   // session datapath: presented balance, validity, idle timer and status pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_id    <= '0;
         r_bal   <= '0;
         r_valid <= 1'b0;
         r_prev  <= 1'b0;
         r_timer <= '0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
         r_eject <= 1'b0;
      end else begin
         r_prev  <= ticket_out;
         r_ok    <= w_commit && w_debit_ok;
         r_err   <= w_commit && !w_debit_ok;
         r_eject <= r_state == S_EJECT;
         if (r_state == S_IDLE && card_insert) r_id <= card_id;
         if (r_state == S_LOAD) begin
            r_bal   <= r_mem[r_id];
            r_valid <= 1'b1;
            r_timer <= '0;
         end else if (r_state == S_EJECT) begin
            r_bal   <= '0;
            r_valid <= 1'b0;
         end else if (w_commit && w_debit_ok) begin
            r_bal <= balance;
         end else if (w_topup) begin
            r_bal   <= w_top_bal;
            r_timer <= '0;
         end else if (w_quiet) begin
            r_timer <= w_tnext;
         end
      end
   end
   assign TC_balance = r_bal;
   assign tc_valid   = r_valid;
   assign card_busy  = r_state != S_IDLE;
   assign write_ok   = r_ok;
   assign write_err  = r_err;
   assign card_eject = r_eject;
endmodule
